// File: rtl/damage_arbiter_ctrl.sv
// Per-frame round controller: round-robin hit arbitration, invulnerability, death and restart.
// Optional MULTI_HIT_EN: every eligible slot is granted in one frame with scaled damage.
module damage_arbiter_ctrl #(
    parameter int unsigned NUM_SRC      = 20,
    parameter int unsigned HP_W         = 10,
    parameter int unsigned IFRAMES      = 30,
    parameter int unsigned DEATH_FRAMES = 60
) (
    input  logic                frame_clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_SRC-1:0]  hit,
    input  logic [1:0]          bullet_state [NUM_SRC],
    input  logic [HP_W-1:0]     damage_unit,
    input  logic [HP_W-1:0]     hp_init,
    output logic [NUM_SRC-1:0]  hit_ack,
    output logic [HP_W-1:0]     hp,
    output logic                invuln,
    output logic [1:0]          state,
    output logic                gameover,
    output logic                restart_req
);

    localparam int unsigned PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CNT_MAX = (IFRAMES > DEATH_FRAMES) ? IFRAMES : DEATH_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PROD_W  = HP_W + 5;

    typedef enum logic [1:0] {StIdle = 2'b00, StPlay = 2'b01, StHurt = 2'b10, StDead = 2'b11} st_e;

    st_e                state_q, state_d;
    logic [HP_W-1:0]    hp_q, hp_d, hp_sub;
    logic [PTR_W-1:0]   ptr_q, ptr_d, play_ptr;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] ack_q, ack_d, play_ack, eligible;
    logic               invuln_q, gameover_q, restart_q, restart_d;
    logic [PROD_W-1:0]  dmg_total;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = hit[i] & ((bullet_state[i] == 2'b01) | (bullet_state[i] == 2'b10));
        end
    end

`ifdef MULTI_HIT_EN
    localparam int unsigned POP_W = $clog2(NUM_SRC + 1);
    logic [POP_W-1:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop = pop + POP_W'(eligible[i]);
        end
    end

    assign dmg_total = PROD_W'(pop) * PROD_W'(damage_unit);
    assign play_ack  = eligible;
    assign play_ptr  = '0;
`else
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   sum;
    logic             found;

    // Scan ptr, ptr+1, ... with wrap; first eligible slot wins.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_SRC)) begin
                sum = sum - (PTR_W+1)'(NUM_SRC);
            end
            if (!found && eligible[sum[PTR_W-1:0]]) begin
                grant_idx = sum[PTR_W-1:0];
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        play_ack            = '0;
        play_ack[grant_idx] = 1'b1;
    end

    assign play_ptr  = (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    assign dmg_total = PROD_W'(damage_unit);
`endif

    assign hp_sub = (dmg_total >= PROD_W'(hp_q)) ? '0 : hp_q - dmg_total[HP_W-1:0];

    always_comb begin
        state_d   = state_q;
        hp_d      = hp_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        restart_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (hp_init == '0) begin
                        state_d = StDead;
                        cnt_d   = CNT_W'(DEATH_FRAMES - 1);
                    end else begin
                        state_d = StPlay;
                    end
                end
            end
            StPlay: begin
                if (|eligible) begin
                    ack_d = play_ack;
                    ptr_d = play_ptr;
                    hp_d  = hp_sub;
                    if (hp_sub == '0) begin
                        state_d = StDead;
                        cnt_d   = CNT_W'(DEATH_FRAMES - 1);
                    end else begin
                        state_d = StHurt;
                        cnt_d   = CNT_W'(IFRAMES - 1);
                    end
                end
            end
            StHurt: begin
                // Clear every live bullet touching us, but apply no damage.
                ack_d = eligible;
                if (cnt_q == '0) begin
                    state_d = StPlay;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDead: begin
                if (cnt_q == '0) begin
                    state_d   = StIdle;
                    restart_d = 1'b1;
                    hp_d      = hp_init;
                    ptr_d     = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (reset) begin
            state_q    <= StIdle;
            hp_q       <= hp_init;
            ptr_q      <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            invuln_q   <= 1'b0;
            gameover_q <= 1'b0;
            restart_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            invuln_q   <= (state_d == StHurt);
            gameover_q <= (state_d == StDead);
            restart_q  <= restart_d;
        end
    end

    assign hit_ack     = ack_q;
    assign hp          = hp_q;
    assign invuln      = invuln_q;
    assign state       = state_q;
    assign gameover    = gameover_q;
    assign restart_req = restart_q;

endmodule

// File: doc/damage_arbiter_ctrl.md
Name: damage_arbiter_ctrl

Overview:
Per-frame game-round controller for the player health datapath.
- Collects hit requests from up to NUM_SRC bullet slots and arbitrates them round-robin, applying at most one damage unit per frame.
- Sequences invulnerability after each hit, then death, then restart.
- Drives the health value, gameover and per-bullet hit acknowledges consumed by the bullet engine and healthbar renderer.

Parameters:
NUM_SRC, 20, number of bullet slots / hit requesters
HP_W, 10, width of health and damage values
IFRAMES, 30, frames spent invulnerable after a damaging hit (>=1)
DEATH_FRAMES, 60, frames held in DEAD before restart (>=1)

Ports:
frame_clk  in  1  frame clock; all state advances on its rising edge
reset  in  1  synchronous, active-high
start  in  1  begin round; sampled only in IDLE
hit  in  NUM_SRC  per-slot collision flags
bullet_state  in  2 x NUM_SRC (unpacked)  per-slot state; 01/10 = live
damage_unit  in  HP_W  damage per granted hit
hp_init  in  HP_W  health loaded at reset and on restart
hit_ack  out  NUM_SRC  registered; bullet slot(s) consumed this frame
hp  out  HP_W  current health (registered)
invuln  out  1  high while in HURT
state  out  2  IDLE=00, PLAY=01, HURT=10, DEAD=11
gameover  out  1  high while in DEAD
restart_req  out  1  one-frame pulse when leaving DEAD

Behaviour:
- Reset (synchronous, active-high) is decided and has priority in every state. Reset values:
  - state=IDLE, hp=hp_init, ptr=0, cnt=0
  - hit_ack=0, invuln=0, gameover=0, restart_req=0
- eligible[i] = hit[i] & (bullet_state[i]==01 | bullet_state[i]==10).
- All outputs are registered: a decision made from inputs at edge N is visible after edge N.
- IDLE:
  - hp is held at hp_init.
  - start=1 -> PLAY, or -> DEAD if hp_init==0.
  - Hits are ignored and hit_ack=0.
- PLAY:
  - No eligible -> stay; hit_ack=0.
  - Otherwise grant g = first eligible index scanning ptr, ptr+1, ... NUM_SRC-1, 0, ... (wrap).
  - hit_ack = one-hot(g) for exactly one frame.
  - ptr <= (g+1) mod NUM_SRC.
  - hp <= sat0(hp - damage_unit), saturating at 0 with no underflow.
  - New hp==0 -> DEAD. Otherwise -> HURT with cnt=IFRAMES-1 and invuln=1.
  - Ungranted eligible slots are not acked and remain pending.
- HURT:
  - Damage is discarded, but every eligible slot is acked each frame so those bullets are cleared.
  - cnt decrements each frame. At cnt==0 -> PLAY and invuln=0.
  - HURT lasts exactly IFRAMES frames.
- DEAD:
  - gameover=1, hit_ack=0, cnt counts DEATH_FRAMES frames.
  - At expiry: restart_req=1 for one frame, hp=hp_init, ptr=0, -> IDLE.
- damage_unit==0: grant, ack and HURT still occur; hp is unchanged.
- damage_unit >= hp: hp=0 and the next state is DEAD. A hit is never "partial".
- start outside IDLE is ignored. hp_init changes take effect only at reset or restart.

Optional Feature:
MULTI_HIT_EN
- Defined: in PLAY, all eligible slots are acked in the same frame, and hp <= sat0(hp - popcount(eligible)*damage_unit). The product is computed at HP_W+5 bits before saturation. ptr is unused and stays 0. HURT/DEAD transitions are unchanged.
- Undefined: round-robin, one grant per frame, exactly as above.

Test Plan:
1. Reset, hp_init=100, pulse start -> state=01 after one frame, hp=100, gameover=0, hit_ack=0.
2. PLAY, damage_unit=10, hit[3] and hit[7] held with bullet_state=01 ->
   - hit_ack=0x00008, hp=90, state=HURT, invuln=1 for exactly 30 frames.
   - Then PLAY, next grant hit_ack=0x00080, hp=80.
3. hit[5]=1 with bullet_state[5]=00, then 11 -> no ack, hp unchanged, state stays PLAY.
4. hp=5, damage_unit=10, one eligible hit -> hp=0, state=DEAD, gameover=1 for 60 frames, restart_req one-frame pulse, then IDLE with hp=100.
5. Wrap check:
   - After granting slot 18 (ptr=19), hits at slots 0 and 19 -> grant 19 first, then 0 after HURT expires.
   - With MULTI_HIT_EN: hits at slots 0 and 19 -> both acked in one frame, hp drops by 20.
6. Assert reset during HURT with cnt=12 -> next edge state=IDLE, hp=hp_init, invuln=0, hit_ack=0, ptr=0.
